// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read-side blocks: default sizes,
// the stream reader state encoding and a small occupancy helper.
package fifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 3;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } rd_state_e;

    // Occupancy after one edge: +1 for an accepted write, -1 for a removal.
    function automatic logic [1:0] occ_next(
        input logic [1:0] occ,
        input logic       inc,
        input logic       dec
    );
        return occ + {1'b0, inc} - {1'b0, dec};
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Downstream valid/ready stream carrying words popped from the FIFO.
// The producer (reader) uses the master modport, the consumer the slave one.
interface fifo_stream_reader_if #(
    parameter int DSIZE = 8
) ();

    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry register buffer between the FIFO read port and the stream.
// The head register is the stream data, so it only changes when the head
// word is removed or when a word lands in an empty buffer.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [DSIZE-1:0] push_data_i,
    input  logic             pop_i,
    output logic [DSIZE-1:0] head_o,
    output logic [1:0]       occ_o,
    output logic             valid_o
);

    logic [DSIZE-1:0] head_q;
    logic [DSIZE-1:0] head_d;
    logic [DSIZE-1:0] tail_q;
    logic [DSIZE-1:0] tail_d;
    logic [1:0]       occ_q;
    logic [1:0]       occ_d;
    logic             valid_q;
    logic             push_s;
    logic             pop_s;

    // Qualify requests (no removal from empty, no write into a full buffer) and compute next contents.
    always_comb begin
        pop_s  = pop_i && (occ_q != 2'd0);
        push_s = push_i && ((occ_q != 2'd2) || pop_s);
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_next(occ_q, push_s, pop_s);
        case ({push_s, pop_s})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = push_data_i;
                end else begin
                    tail_d = push_data_i;
                end
            end
            2'b01: begin
                head_d = tail_q;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: begin
                head_d = head_q;
            end
        endcase
    end

    // Buffer storage, occupancy and registered valid flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            valid_q <= (occ_d != 2'd0);
        end
    end

    assign head_o  = head_q;
    assign occ_o   = occ_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer of the async FIFO: pops words under an enable, buffers
// them in a 2-entry skid buffer and presents them as a registered
// valid/ready stream, counting completed handshakes.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  en,
    input  logic [DSIZE-1:0]      rdata,
    input  logic                  rempty,
    output logic                  rinc,
    fifo_stream_reader_if.master  m_if,
    output logic                  busy,
    output logic [CNT_W-1:0]      word_cnt
);

    rd_state_e        state_q;
    rd_state_e        state_d;
    logic [1:0]       occ_s;
    logic [DSIZE-1:0] head_s;
    logic             valid_s;
    logic             hs_s;
    logic [CNT_W-1:0] word_cnt_q;
    logic [CNT_W-1:0] word_cnt_d;

    assign hs_s = valid_s && m_if.m_ready;

    fifo_rd_skid #(
        .DSIZE(DSIZE)
    ) u_skid (
        .clk_i       (rclk),
        .rst_i       (rrst),
        .push_i      (rinc),
        .push_data_i (rdata),
        .pop_i       (hs_s),
        .head_o      (head_s),
        .occ_o       (occ_s),
        .valid_o     (valid_s)
    );

    // State register.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; leaving ACTIVE keeps buffered words flowing in DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = ACTIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (en) begin
                    state_d = ACTIVE;
                end else if (occ_s != 2'd0) begin
                    state_d = DRAIN;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (en) begin
                    state_d = ACTIVE;
                end else if (occ_s == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state: pop only with data and a free slot.
    always_comb begin
        rinc = (state_q == ACTIVE) && !rempty && (occ_s < 2'd2);
        busy = (state_q != IDLE);
    end

    // Next value of the delivered-word counter; wraps naturally.
    always_comb begin
        if (hs_s) begin
            word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            word_cnt_d = word_cnt_q;
        end
    end

    // Delivered-word counter register.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            word_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_cnt     = word_cnt_q;
    assign m_if.m_data  = head_s;
    assign m_if.m_valid = valid_s;

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

    localparam int M_IDLE   = 0;
    localparam int M_ACTIVE = 1;
    localparam int M_DRAIN  = 2;

    logic        rclk;
    logic        rrst;
    logic        en;
    logic [7:0]  rdata;
    logic        rempty;
    logic        rinc;
    logic        busy;
    logic [15:0] word_cnt;

    logic        en2;
    logic [7:0]  rdata2;
    logic        rempty2;
    logic        rinc2;
    logic        busy2;
    logic [3:0]  word_cnt2;

    fifo_stream_reader_if #(.DSIZE(8)) s_if ();
    fifo_stream_reader_if #(.DSIZE(8)) s2_if ();

    fifo_stream_reader #(.DSIZE(8), .CNT_W(16)) dut (
        .rclk(rclk), .rrst(rrst), .en(en), .rdata(rdata), .rempty(rempty),
        .rinc(rinc), .m_if(s_if), .busy(busy), .word_cnt(word_cnt)
    );

    fifo_stream_reader #(.DSIZE(8), .CNT_W(4)) dut_w (
        .rclk(rclk), .rrst(rrst), .en(en2), .rdata(rdata2), .rempty(rempty2),
        .rinc(rinc2), .m_if(s2_if), .busy(busy2), .word_cnt(word_cnt2)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: FIFO contents, buffered words, mode, delivered count
    logic [7:0]  fifo_q[$];
    logic [7:0]  ref_buf[$];
    int          ref_mode = M_IDLE;
    logic [15:0] exp_cnt = 16'd0;
    logic        force_empty = 1'b0;
    int          cyc = 0;
    int          n_rinc, n_hs, rinc_first, rinc_last, hs_first, hs_last;

    task automatic clear_counts();
        n_rinc = 0; n_hs = 0;
        rinc_first = -1; rinc_last = -1; hs_first = -1; hs_last = -1;
    endtask

    // one clock of the main DUT, checked against the reference model
    task automatic run_cycle();
        logic exp_rinc, exp_valid, exp_hs;
        int occ;
        @(negedge rclk);
        rempty = force_empty || (fifo_q.size() == 0);
        rdata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'($urandom);
        #1;
        occ       = ref_buf.size();
        exp_rinc  = (ref_mode == M_ACTIVE) && !rempty && (occ < 2);
        exp_valid = (occ > 0);
        exp_hs    = exp_valid && s_if.m_ready;
        n_cmp++;
        if (rinc !== exp_rinc) begin
            n_err++; $display("FAIL cyc_rinc c=%0d got %b want %b", cyc, rinc, exp_rinc);
        end
        n_cmp++;
        if (s_if.m_valid !== exp_valid) begin
            n_err++; $display("FAIL cyc_valid c=%0d got %b want %b", cyc, s_if.m_valid, exp_valid);
        end
        n_cmp++;
        if (busy !== (ref_mode != M_IDLE)) begin
            n_err++; $display("FAIL cyc_busy c=%0d got %b want %b", cyc, busy, ref_mode != M_IDLE);
        end
        n_cmp++;
        if (word_cnt !== exp_cnt) begin
            n_err++; $display("FAIL cyc_cnt c=%0d got %0d want %0d", cyc, word_cnt, exp_cnt);
        end
        if (exp_valid) begin
            n_cmp++;
            if (s_if.m_data !== ref_buf[0]) begin
                n_err++; $display("FAIL cyc_data c=%0d got %h want %h", cyc, s_if.m_data, ref_buf[0]);
            end
        end
        if (rinc === 1'b1) begin
            n_rinc++; if (rinc_first < 0) rinc_first = cyc; rinc_last = cyc;
        end
        if (exp_hs) begin
            n_hs++; if (hs_first < 0) hs_first = cyc; hs_last = cyc;
        end
        @(posedge rclk);
        case (ref_mode)
            M_IDLE:   if (en) ref_mode = M_ACTIVE;
            M_ACTIVE: if (!en) ref_mode = (occ > 0) ? M_DRAIN : M_IDLE;
            M_DRAIN:  if (en) ref_mode = M_ACTIVE; else if (occ == 0) ref_mode = M_IDLE;
            default:  ref_mode = M_IDLE;
        endcase
        if (exp_hs) begin
            void'(ref_buf.pop_front());
            exp_cnt = exp_cnt + 16'd1;
        end
        if (exp_rinc) ref_buf.push_back(fifo_q.pop_front());
        cyc++;
        #1;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (s_if.m_valid !== 1'b0 || word_cnt !== 16'd0 || busy !== 1'b0 ||
            rinc !== 1'b0 || s_if.m_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_vals got v=%b cnt=%0d busy=%b rinc=%b d=%h want 0 0 0 0 00",
                     s_if.m_valid, word_cnt, busy, rinc, s_if.m_data);
        end
        rrst = 1'b0;
        run_n(3);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_empty_hold();
        force_empty = 1'b1; en = 1'b1; s_if.m_ready = 1'b1;
        clear_counts();
        run_n(20);
        n_cmp++;
        if (n_rinc != 0 || s_if.m_valid !== 1'b0 || word_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL empty_hold got rinc_n=%0d v=%b cnt=%0d want 0 0 0", n_rinc, s_if.m_valid, word_cnt);
        end
        en = 1'b0; force_empty = 1'b0;
        run_n(3);
    endtask

    task automatic test_three_words();
        fifo_q = '{8'h11, 8'h22, 8'h33};
        en = 1'b1; s_if.m_ready = 1'b1;
        clear_counts();
        run_n(6);
        n_cmp++;
        if (n_rinc != 3 || rinc_last - rinc_first != 2) begin
            n_err++; $display("FAIL three_rinc got n=%0d span=%0d want 3 2", n_rinc, rinc_last - rinc_first);
        end
        n_cmp++;
        if (n_hs != 3 || hs_last - hs_first != 2) begin
            n_err++; $display("FAIL three_hs got n=%0d span=%0d want 3 2", n_hs, hs_last - hs_first);
        end
        n_cmp++;
        if (word_cnt !== 16'd3 || rinc !== 1'b0) begin
            n_err++; $display("FAIL three_end got cnt=%0d rinc=%b want 3 0", word_cnt, rinc);
        end
        en = 1'b0;
        run_n(3);
    endtask

    task automatic test_backpressure();
        logic [7:0]  w0;
        logic [15:0] base;
        w0 = 8'($urandom);
        fifo_q.push_back(w0);
        for (int i = 1; i < 8; i++) fifo_q.push_back(8'($urandom));
        base = exp_cnt;
        en = 1'b1; s_if.m_ready = 1'b0;
        clear_counts();
        run_n(10);
        n_cmp++;
        if (n_rinc != 2 || rinc !== 1'b0) begin
            n_err++; $display("FAIL bp_pops got n=%0d rinc=%b want 2 0", n_rinc, rinc);
        end
        n_cmp++;
        if (s_if.m_valid !== 1'b1 || s_if.m_data !== w0) begin
            n_err++; $display("FAIL bp_hold got v=%b d=%h want 1 %h", s_if.m_valid, s_if.m_data, w0);
        end
        s_if.m_ready = 1'b1;
        run_n(20);
        n_cmp++;
        if (n_hs != 8 || word_cnt !== base + 16'd8) begin
            n_err++; $display("FAIL bp_release got hs=%0d cnt=%0d want 8 %0d", n_hs, word_cnt, base + 16'd8);
        end
        en = 1'b0;
        run_n(3);
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'($urandom));
        en = 1'b1; s_if.m_ready = 1'b0;
        run_n(4);
        en = 1'b0;
        run_cycle();
        clear_counts();
        run_n(3);
        n_cmp++;
        if (n_rinc != 0 || busy !== 1'b1 || s_if.m_valid !== 1'b1) begin
            n_err++; $display("FAIL drain_hold got rinc_n=%0d busy=%b v=%b want 0 1 1", n_rinc, busy, s_if.m_valid);
        end
        s_if.m_ready = 1'b1;
        run_n(4);
        n_cmp++;
        if (n_hs != 2 || busy !== 1'b0 || s_if.m_valid !== 1'b0) begin
            n_err++; $display("FAIL drain_done got hs=%0d busy=%b v=%b want 2 0 0", n_hs, busy, s_if.m_valid);
        end
        fifo_q.delete();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            en           = ($urandom_range(0, 9) < 8);
            s_if.m_ready = 1'($urandom_range(0, 1));
            force_empty  = ($urandom_range(0, 9) == 0);
            if (fifo_q.size() < 8 && $urandom_range(0, 2) == 0) fifo_q.push_back(8'($urandom));
            run_cycle();
        end
        en = 1'b1; s_if.m_ready = 1'b1; force_empty = 1'b0;
        run_n(12);
        en = 1'b0;
        run_n(4);
        n_cmp++;
        if (busy !== 1'b0 || s_if.m_valid !== 1'b0) begin
            n_err++; $display("FAIL rand_settle got busy=%b v=%b want 0 0", busy, s_if.m_valid);
        end
    endtask

    task automatic test_async_reset();
        fifo_q = '{8'hA1, 8'hA2, 8'hA3};
        en = 1'b1; s_if.m_ready = 1'b1;
        run_n(3);
        s_if.m_ready = 1'b0;
        run_n(4);
        n_cmp++;
        if (s_if.m_valid !== 1'b1 || word_cnt === 16'd0) begin
            n_err++; $display("FAIL arst_pre got v=%b cnt=%0d want 1 nonzero", s_if.m_valid, word_cnt);
        end
        rrst = 1'b1;
        #1;
        n_cmp++;
        if (s_if.m_valid !== 1'b0 || word_cnt !== 16'd0 || busy !== 1'b0 || rinc !== 1'b0) begin
            n_err++;
            $display("FAIL arst_now got v=%b cnt=%0d busy=%b rinc=%b want 0 0 0 0",
                     s_if.m_valid, word_cnt, busy, rinc);
        end
        #1;
        rrst = 1'b0;
        en = 1'b0;
        fifo_q.delete(); ref_buf.delete();
        ref_mode = M_IDLE; exp_cnt = 16'd0;
        run_n(3);
    endtask

    task automatic test_wrap();
        logic [7:0] sent[$];
        logic [7:0] feed[$];
        int hs2;
        for (int i = 0; i < 17; i++) sent.push_back(8'($urandom));
        feed = sent;
        hs2 = 0;
        en2 = 1'b1; s2_if.m_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge rclk);
            rempty2 = (feed.size() == 0);
            rdata2  = (feed.size() > 0) ? feed[0] : 8'h00;
            #1;
            if (s2_if.m_valid === 1'b1) begin
                n_cmp++;
                if (hs2 >= 17) begin
                    n_err++; $display("FAIL wrap_extra got word %h want none", s2_if.m_data);
                end else if (s2_if.m_data !== sent[hs2]) begin
                    n_err++; $display("FAIL wrap_data i=%0d got %h want %h", hs2, s2_if.m_data, sent[hs2]);
                end
                hs2++;
            end
            if (rinc2 === 1'b1 && feed.size() > 0) void'(feed.pop_front());
            @(posedge rclk);
            #1;
        end
        n_cmp++;
        if (hs2 != 17 || word_cnt2 !== 4'd1) begin
            n_err++; $display("FAIL wrap_cnt got hs=%0d cnt=%0d want 17 1", hs2, word_cnt2);
        end
        en2 = 1'b0;
    endtask

    initial begin
        rrst = 1'b1; en = 1'b0; rdata = 8'h00; rempty = 1'b1;
        s_if.m_ready = 1'b0;
        en2 = 1'b0; rdata2 = 8'h00; rempty2 = 1'b1; s2_if.m_ready = 1'b0;
        clear_counts();
        test_reset();
        test_empty_hold();
        test_three_words();
        test_backpressure();
        test_drain();
        test_random();
        test_async_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
